// File: rtl/constraint_score_accumulator.sv
// Per-frame constraint score accumulator: counts satisfied constraints for the proposed (u) and
// current (v) assignments and hands the saturating 8-bit pair downstream under valid/ack.
// Optional macro WEIGHTED_SCORE_EN: each satisfied constraint adds in_weight instead of 1.
module constraint_score_accumulator #(
  parameter int MAX_CONSTRAINTS = 64,
  parameter int WEIGHT_WIDTH    = 4
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_start,
  input  logic                    in_valid,
  output logic                    out_ready,
  input  logic                    in_sat_proposed,
  input  logic                    in_sat_current,
  input  logic                    in_last,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  output logic [7:0]              out_u,
  output logic [7:0]              out_v,
  output logic                    out_valid,
  input  logic                    in_ack,
  output logic                    out_error
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_CONSTRAINTS - 1);

  state_t     state;
  logic [7:0] sum_u;
  logic [7:0] sum_v;
  logic [7:0] beat_cnt;
  logic [7:0] next_u;
  logic [7:0] next_v;
  logic       frame_end;

`ifdef WEIGHTED_SCORE_EN
  logic [8:0] add_u;
  logic [8:0] add_v;

  // 9-bit sum: bit 8 set means the 8-bit score would have wrapped, so clamp.
  assign add_u  = {1'b0, sum_u} + (in_sat_proposed ? 9'(in_weight) : 9'd0);
  assign add_v  = {1'b0, sum_v} + (in_sat_current  ? 9'(in_weight) : 9'd0);
  assign next_u = add_u[8] ? 8'hFF : add_u[7:0];
  assign next_v = add_v[8] ? 8'hFF : add_v[7:0];
`else
  logic unused_weight;

  assign unused_weight = ^in_weight;
  assign next_u = (in_sat_proposed && (sum_u != 8'hFF)) ? sum_u + 8'd1 : sum_u;
  assign next_v = (in_sat_current  && (sum_v != 8'hFF)) ? sum_v + 8'd1 : sum_v;
`endif

  assign frame_end = in_last || (beat_cnt == LAST_BEAT);

  // Pure decode of the state register, so no input-to-output combinational path.
  assign out_ready = (state == ACCUM);

  // NOTE: every register here is written with <= so all updates see the pre-edge values.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state     <= IDLE;
      sum_u     <= 8'd0;
      sum_v     <= 8'd0;
      beat_cnt  <= 8'd0;
      out_u     <= 8'd0;
      out_v     <= 8'd0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            state     <= ACCUM;
            sum_u     <= 8'd0;
            sum_v     <= 8'd0;
            beat_cnt  <= 8'd0;
            out_error <= 1'b0;
          end
        end

        ACCUM: begin
          if (in_start) begin
            // Restart wins over any beat presented in the same cycle.
            sum_u    <= 8'd0;
            sum_v    <= 8'd0;
            beat_cnt <= 8'd0;
          end else if (in_valid) begin
            sum_u    <= next_u;
            sum_v    <= next_v;
            beat_cnt <= beat_cnt + 8'd1;
            if (frame_end) begin
              out_u     <= next_u;
              out_v     <= next_v;
              out_valid <= 1'b1;
              out_error <= ~in_last;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (in_ack) begin
            out_valid <= 1'b0;
            if (in_start) begin
              state     <= ACCUM;
              sum_u     <= 8'd0;
              sum_v     <= 8'd0;
              beat_cnt  <= 8'd0;
              out_error <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_constraint_score_accumulator.sv
// Directed bench for constraint_score_accumulator: a MAX_CONSTRAINTS=4 instance for framing,
// truncation, restart and handshake cases, and a MAX_CONSTRAINTS=255 instance for long frames.
module tb_constraint_score_accumulator;

`ifdef WEIGHTED_SCORE_EN
  localparam int WU = 3;          // score per satisfied beat on the small instance (weight 3)
  localparam bit WEIGHTED = 1'b1;
`else
  localparam int WU = 1;
  localparam bit WEIGHTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_start, a_valid, a_p, a_c, a_last, a_ack;
  logic [3:0] a_weight;
  logic       a_ready, a_out_valid, a_error;
  logic [7:0] a_u, a_v;

  logic       b_start, b_valid, b_p, b_c, b_last, b_ack;
  logic [3:0] b_weight;
  logic       b_ready, b_out_valid, b_error;
  logic [7:0] b_u, b_v;

  logic [18:0] a_st, b_st;
  int n_vec = 0;
  int n_err = 0;

  assign a_st = {a_out_valid, a_ready, a_error, a_u, a_v};
  assign b_st = {b_out_valid, b_ready, b_error, b_u, b_v};

  always #5 clk = ~clk;

  constraint_score_accumulator #(.MAX_CONSTRAINTS(4), .WEIGHT_WIDTH(4)) dut (
    .in_clock(clk), .in_reset(rst), .in_start(a_start), .in_valid(a_valid),
    .out_ready(a_ready), .in_sat_proposed(a_p), .in_sat_current(a_c), .in_last(a_last),
    .in_weight(a_weight), .out_u(a_u), .out_v(a_v), .out_valid(a_out_valid),
    .in_ack(a_ack), .out_error(a_error)
  );

  constraint_score_accumulator #(.MAX_CONSTRAINTS(255), .WEIGHT_WIDTH(4)) dut255 (
    .in_clock(clk), .in_reset(rst), .in_start(b_start), .in_valid(b_valid),
    .out_ready(b_ready), .in_sat_proposed(b_p), .in_sat_current(b_c), .in_last(b_last),
    .in_weight(b_weight), .out_u(b_u), .out_v(b_v), .out_valid(b_out_valid),
    .in_ack(b_ack), .out_error(b_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic start, valid, p, c, last, ack);
    a_start = start; a_valid = valid; a_p = p; a_c = c; a_last = last; a_ack = ack;
  endtask

  task automatic set_b(input logic start, valid, p, c, last, ack, input logic [3:0] w);
    b_start = start; b_valid = valid; b_p = p; b_c = c; b_last = last; b_ack = ack;
    b_weight = w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 4'd1);
    a_weight = 4'd3;
    step(); step();
    n_vec++;
    if (a_st !== 19'd0) begin
      n_err++; $display("FAIL reset_small: got %h want %h", a_st, 19'd0);
    end
    n_vec++;
    if (b_st !== 19'd0) begin
      n_err++; $display("FAIL reset_large: got %h want %h", b_st, 19'd0);
    end
    #2 rst = 1'b0;
    step();
  endtask

  // (1,1),(1,0),(0,1) with last on beat 3 -> u=2, v=2 held until ack.
  task automatic test_basic_frame();
    logic [18:0] exp_done;
    exp_done = {1'b1, 1'b0, 1'b0, 8'(2 * WU), 8'(2 * WU)};
    set_a(1, 0, 0, 0, 0, 0); step();
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_ready: got %b want 1", a_ready);
    end
    set_a(0, 1, 1, 1, 0, 0); step();
    set_a(0, 1, 1, 0, 0, 0); step();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: got %b want 0", a_out_valid);
    end
    set_a(0, 1, 0, 1, 1, 0); step();
    n_vec++;
    if (a_st !== exp_done) begin
      n_err++; $display("FAIL basic_result: got %h want %h", a_st, exp_done);
    end
    set_a(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (a_st !== exp_done) begin
        n_err++; $display("FAIL basic_hold%0d: got %h want %h", i, a_st, exp_done);
      end
    end
    set_a(0, 0, 0, 0, 0, 1); step();
    n_vec++;
    if (a_st !== {1'b0, 1'b0, 1'b0, 8'(2 * WU), 8'(2 * WU)}) begin
      n_err++; $display("FAIL basic_ack: got %h want %h", a_st,
                        {1'b0, 1'b0, 1'b0, 8'(2 * WU), 8'(2 * WU)});
    end
    // Back in IDLE: a stray beat without start must not be taken.
    set_a(0, 1, 1, 1, 1, 0); step();
    n_vec++;
    if (a_st !== {1'b0, 1'b0, 1'b0, 8'(2 * WU), 8'(2 * WU)}) begin
      n_err++; $display("FAIL idle_ignores_beat: got %h want %h", a_st,
                        {1'b0, 1'b0, 1'b0, 8'(2 * WU), 8'(2 * WU)});
    end
    set_a(0, 0, 0, 0, 0, 0);
  endtask

  // MAX_CONSTRAINTS=4, six beats, no last -> closes on beat 4 with error.
  task automatic test_truncation();
    set_a(1, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      set_a(0, 1, 1, 0, 0, 0);
      n_vec++;
      if (a_ready !== (i < 4)) begin
        n_err++; $display("FAIL trunc_ready_beat%0d: got %b want %b", i + 1, a_ready, i < 4);
      end
      step();
    end
    n_vec++;
    if (a_st !== {1'b1, 1'b0, 1'b1, 8'(4 * WU), 8'd0}) begin
      n_err++; $display("FAIL trunc_result: got %h want %h", a_st,
                        {1'b1, 1'b0, 1'b1, 8'(4 * WU), 8'd0});
    end
    set_a(0, 0, 0, 0, 0, 1); step();
    n_vec++;
    if (a_st !== {1'b0, 1'b0, 1'b1, 8'(4 * WU), 8'd0}) begin
      n_err++; $display("FAIL trunc_error_sticky: got %h want %h", a_st,
                        {1'b0, 1'b0, 1'b1, 8'(4 * WU), 8'd0});
    end
    set_a(1, 0, 0, 0, 0, 0); step();
    n_vec++;
    if (a_st !== {1'b0, 1'b1, 1'b0, 8'(4 * WU), 8'd0}) begin
      n_err++; $display("FAIL trunc_error_clear: got %h want %h", a_st,
                        {1'b0, 1'b1, 1'b0, 8'(4 * WU), 8'd0});
    end
    set_a(0, 0, 0, 0, 0, 0);
  endtask

  // Restart mid-frame with a beat in the same cycle: that beat is dropped.
  task automatic test_restart_drop();
    set_a(1, 0, 0, 0, 0, 0); step();
    set_a(0, 1, 1, 1, 0, 0); step(); step();
    set_a(1, 1, 1, 1, 0, 0);
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_err++; $display("FAIL drop_ready: got %b want 1", a_ready);
    end
    step();
    set_a(0, 1, 1, 0, 1, 0); step();
    n_vec++;
    if (a_st !== {1'b1, 1'b0, 1'b0, 8'(WU), 8'd0}) begin
      n_err++; $display("FAIL drop_result: got %h want %h", a_st,
                        {1'b1, 1'b0, 1'b0, 8'(WU), 8'd0});
    end
    set_a(0, 0, 0, 0, 0, 1); step();
    set_a(0, 0, 0, 0, 0, 0);
  endtask

  // DONE ignores start alone; ack+start restarts with a beat taken the next cycle.
  task automatic test_back_to_back();
    logic [18:0] exp_done;
    exp_done = {1'b1, 1'b0, 1'b0, 8'(WU), 8'(WU)};
    set_a(1, 0, 0, 0, 0, 0); step();
    set_a(0, 1, 1, 1, 1, 0); step();
    for (int i = 0; i < 3; i++) begin
      set_a(1, 1, 0, 0, 1, 0); step();
      n_vec++;
      if (a_st !== exp_done) begin
        n_err++; $display("FAIL done_start_only%0d: got %h want %h", i, a_st, exp_done);
      end
    end
    set_a(1, 0, 0, 0, 0, 1); step();
    n_vec++;
    if (a_st !== {1'b0, 1'b1, 1'b0, 8'(WU), 8'(WU)}) begin
      n_err++; $display("FAIL ack_start: got %h want %h", a_st,
                        {1'b0, 1'b1, 1'b0, 8'(WU), 8'(WU)});
    end
    set_a(0, 1, 0, 1, 1, 0); step();
    n_vec++;
    if (a_st !== {1'b1, 1'b0, 1'b0, 8'd0, 8'(WU)}) begin
      n_err++; $display("FAIL b2b_result: got %h want %h", a_st,
                        {1'b1, 1'b0, 1'b0, 8'd0, 8'(WU)});
    end
    set_a(0, 0, 0, 0, 0, 1); step();
    set_a(0, 0, 0, 0, 0, 0);
  endtask

  // Reset mid-frame and in DONE clears everything without a clock edge.
  task automatic test_async_reset();
    set_a(1, 0, 0, 0, 0, 0); step();
    set_a(0, 1, 1, 1, 0, 0); step(); step();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (a_st !== 19'd0) begin
      n_err++; $display("FAIL reset_midframe: got %h want %h", a_st, 19'd0);
    end
    #1 rst = 1'b0;
    step();
    set_a(1, 0, 0, 0, 0, 0); step();
    set_a(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (a_st !== {1'b1, 1'b0, 1'b1, 8'(4 * WU), 8'(4 * WU)}) begin
      n_err++; $display("FAIL reset_pre_done: got %h want %h", a_st,
                        {1'b1, 1'b0, 1'b1, 8'(4 * WU), 8'(4 * WU)});
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (a_st !== 19'd0) begin
      n_err++; $display("FAIL reset_in_done: got %h want %h", a_st, 19'd0);
    end
    #1 rst = 1'b0;
    step();
    // State must be IDLE: a beat without start is ignored.
    set_a(0, 1, 1, 1, 1, 0); step();
    n_vec++;
    if (a_st !== 19'd0) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", a_st, 19'd0);
    end
    set_a(0, 0, 0, 0, 0, 0);
  endtask

  // 255-beat frame on the large instance, then a 20-beat weight-15 frame.
  task automatic test_long_frame();
    logic [7:0] exp_u, exp_v;
    set_b(1, 0, 0, 0, 0, 0, 4'd1); step();
    for (int i = 0; i < 255; i++) begin
      set_b(0, 1, 1, 0, (i == 254), 0, 4'd1);
      if (i == 254) begin
        n_vec++;
        if (b_st !== {1'b0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
          n_err++; $display("FAIL long_before_last: got %h want %h", b_st,
                            {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
        end
      end
      step();
    end
    n_vec++;
    if (b_st !== {1'b1, 1'b0, 1'b0, 8'd255, 8'd0}) begin
      n_err++; $display("FAIL long_result: got %h want %h", b_st,
                        {1'b1, 1'b0, 1'b0, 8'd255, 8'd0});
    end
    set_b(0, 0, 0, 0, 0, 1, 4'd1); step();
    exp_u = WEIGHTED ? 8'd255 : 8'd20;
    exp_v = WEIGHTED ? 8'd30  : 8'd2;
    set_b(1, 0, 0, 0, 0, 0, 4'd15); step();
    for (int i = 0; i < 20; i++) begin
      set_b(0, 1, 1, (i < 2), (i == 19), 0, 4'd15);
      step();
    end
    n_vec++;
    if (b_st !== {1'b1, 1'b0, 1'b0, exp_u, exp_v}) begin
      n_err++; $display("FAIL weighted_saturate: got %h want %h", b_st,
                        {1'b1, 1'b0, 1'b0, exp_u, exp_v});
    end
    set_b(0, 0, 0, 0, 0, 1, 4'd15); step();
    set_b(0, 0, 0, 0, 0, 0, 4'd1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_truncation();
    test_restart_drop();
    test_back_to_back();
    test_long_frame();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
